// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS I execute unit.
// Provides the ALU operation code enumeration used by the decoder and the ALU.
package mips_alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_SLT   = 5'd5,
    OP_SLTU  = 5'd6,
    OP_SLL   = 5'd7,
    OP_SRL   = 5'd8,
    OP_SRA   = 5'd9,
    OP_LUI   = 5'd10,
    OP_MULT  = 5'd11,
    OP_MULTU = 5'd12,
    OP_DIV   = 5'd13,
    OP_DIVU  = 5'd14,
    OP_MTHI  = 5'd15,
    OP_MTLO  = 5'd16,
    OP_MFHI  = 5'd17,
    OP_MFLO  = 5'd18,
    OP_BEQ   = 5'd19,
    OP_BNE   = 5'd20,
    OP_BGEZ  = 5'd21,
    OP_BGTZ  = 5'd22,
    OP_BLEZ  = 5'd23,
    OP_BLTZ  = 5'd24,
    OP_PASS  = 5'd25
  } alu_op_t;

endpackage

// File: rtl/mips_alu_unit_if.sv
// Execute-unit operand/result bundle between the decoder/datapath and the ALU.
//   ALUControl : operation code (alu_op_t encoding)
//   alu_src_1  : operand A (rs, or shift amount in [4:0])
//   alu_src_2  : operand B (rt, or sign-extended immediate)
//   alu_result : combinational result
//   branch     : combinational branch condition
interface mips_alu_unit_if;
  import mips_alu_pkg::*;

  logic [OP_W-1:0]   ALUControl;
  logic [DATA_W-1:0] alu_src_1;
  logic [DATA_W-1:0] alu_src_2;
  logic [DATA_W-1:0] alu_result;
  logic              branch;

  modport master (
    output ALUControl, alu_src_1, alu_src_2,
    input  alu_result, branch
  );

  modport slave (
    input  ALUControl, alu_src_1, alu_src_2,
    output alu_result, branch
  );

endinterface

// File: rtl/mips_alu_muldiv.sv
// HI/LO register pair with multiply, divide and move-to operations.
//   clk, rst : clock, synchronous active-high reset (clears HI/LO)
//   op       : current ALU operation; HI/LO written on MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   a, b     : operands
//   hi, lo   : current HI/LO register contents
module mips_alu_muldiv
  import mips_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;
  logic [DATA_W-1:0]   div_b;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [DATA_W-1:0]   uq;
  logic [DATA_W-1:0]   ur;
  logic [DATA_W-1:0]   sq_mag;
  logic [DATA_W-1:0]   sr_mag;
  logic [DATA_W-1:0]   sq;
  logic [DATA_W-1:0]   sr;
  logic                b_zero;

  // Products: sign-extend to 64 bits for the signed form.
  always_comb begin
    prod_s = 64'($signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b}));
    prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  end

  // Signed division via magnitudes, so 0x80000000 / -1 wraps cleanly to 0x80000000.
  // A zero divisor is replaced by 1 only to keep the divider defined; the result is discarded.
  always_comb begin
    b_zero = (b == '0);
    div_b  = b_zero ? DATA_W'(1) : b;
    a_mag  = a[DATA_W-1] ? (~a + DATA_W'(1)) : a;
    b_mag  = div_b[DATA_W-1] ? (~div_b + DATA_W'(1)) : div_b;
    uq     = a / div_b;
    ur     = a % div_b;
    sq_mag = a_mag / b_mag;
    sr_mag = a_mag % b_mag;
    sq     = (a[DATA_W-1] ^ b[DATA_W-1]) ? (~sq_mag + DATA_W'(1)) : sq_mag;
    sr     = a[DATA_W-1] ? (~sr_mag + DATA_W'(1)) : sr_mag;
  end

  // HI/LO update; reset wins over any simultaneous write.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      case (op)
        OP_MULT: begin
          hi <= prod_s[2*DATA_W-1:DATA_W];
          lo <= prod_s[DATA_W-1:0];
        end
        OP_MULTU: begin
          hi <= prod_u[2*DATA_W-1:DATA_W];
          lo <= prod_u[DATA_W-1:0];
        end
        OP_DIV: begin
          if (!b_zero) begin
            hi <= sr;
            lo <= sq;
          end
        end
        OP_DIVU: begin
          if (!b_zero) begin
            hi <= ur;
            lo <= uq;
          end
        end
        OP_MTHI: hi <= a;
        OP_MTLO: lo <= a;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mips_alu_unit.sv
// MIPS I execute unit: integer ALU, shifter, branch comparator and HI/LO block.
//   clk, rst : clock, synchronous active-high reset (HI/LO only)
//   bus      : slave side of mips_alu_unit_if; alu_result and branch are combinational
module mips_alu_unit
  import mips_alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mips_alu_unit_if.slave bus
);

  alu_op_t              op;
  logic [DATA_W-1:0]    a;
  logic [DATA_W-1:0]    b;
  logic [SHAMT_W-1:0]   shamt;
  logic [DATA_W-1:0]    hi;
  logic [DATA_W-1:0]    lo;
  logic [DATA_W-1:0]    result;
  logic                 br;

  assign op    = alu_op_t'(bus.ALUControl);
  assign a     = bus.alu_src_1;
  assign b     = bus.alu_src_2;
  assign shamt = a[SHAMT_W-1:0];

  mips_alu_muldiv u_muldiv (
    .clk (clk),
    .rst (rst),
    .op  (op),
    .a   (a),
    .b   (b),
    .hi  (hi),
    .lo  (lo)
  );

  // Result mux and branch compare; undefined codes fall to zero.
  always_comb begin
    result = '0;
    br     = 1'b0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = DATA_W'($signed(a) < $signed(b));
      OP_SLTU: result = DATA_W'(a < b);
      OP_SLL:  result = b << shamt;
      OP_SRL:  result = b >> shamt;
      OP_SRA:  result = DATA_W'($signed(b) >>> shamt);
      OP_LUI:  result = {b[15:0], 16'h0000};
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      OP_PASS: result = a;
      OP_BEQ:  br = (a == b);
      OP_BNE:  br = (a != b);
      OP_BGEZ: br = ~a[DATA_W-1];
      OP_BGTZ: br = ~a[DATA_W-1] & (a != '0);
      OP_BLEZ: br = a[DATA_W-1] | (a == '0);
      OP_BLTZ: br = a[DATA_W-1];
      default: ;
    endcase
  end

  assign bus.alu_result = result;
  assign bus.branch     = br;

endmodule

// File: tb/tb_mips_alu_unit.sv
module tb_mips_alu_unit;
  import mips_alu_pkg::*;

  logic clk;
  logic rst;

  mips_alu_unit_if bus ();

  mips_alu_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        br;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec;
  int    n_err;

  // Drive one vector just after the rising edge and queue its expected response.
  task automatic apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic r, input logic [31:0] exp_res, input logic exp_br,
                       input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = r;
    bus.ALUControl = op;
    bus.alu_src_1  = a;
    bus.alu_src_2  = b;
    e.res = exp_res;
    e.br  = exp_br;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Monitor: the response is present every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if (bus.alu_result !== e.res || bus.branch !== e.br) begin
        n_err++;
        $display("FAIL %s: got result=%h branch=%b, want result=%h branch=%b",
                 nm, bus.alu_result, bus.branch, e.res, e.br);
      end
    end
  end

  initial begin
    int wait_cyc;
    n_vec = 0;
    n_err = 0;
    rst            = 1'b1;
    bus.ALUControl = OP_ADD;
    bus.alu_src_1  = '0;
    bus.alu_src_2  = '0;

    apply(OP_ADD,   32'd1,        32'd2,        1'b1, 32'd3,        1'b0, "add_in_reset");
    apply(OP_ADD,   32'd1,        32'd2,        1'b1, 32'd3,        1'b0, "add_in_reset2");
    apply(OP_MFHI,  32'd0,        32'd0,        1'b0, 32'd0,        1'b0, "reset_hi");
    apply(OP_MFLO,  32'd0,        32'd0,        1'b0, 32'd0,        1'b0, "reset_lo");

    apply(OP_ADD,   32'hFFFFFFFF, 32'd1,        1'b0, 32'h0,        1'b0, "add_wrap");
    apply(OP_SUB,   32'd0,        32'd1,        1'b0, 32'hFFFFFFFF, 1'b0, "sub_wrap");
    apply(OP_AND,   32'h0000F0F0, 32'h0000FF00, 1'b0, 32'h0000F000, 1'b0, "and");
    apply(OP_OR,    32'h0000F0F0, 32'h0000FF00, 1'b0, 32'h0000FFF0, 1'b0, "or");
    apply(OP_XOR,   32'h0000F0F0, 32'h0000FF00, 1'b0, 32'h00000FF0, 1'b0, "xor");
    apply(OP_SLT,   32'hFFFFFFFF, 32'd1,        1'b0, 32'd1,        1'b0, "slt");
    apply(OP_SLTU,  32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,        1'b0, "sltu");
    apply(OP_SLL,   32'd4,        32'd1,        1'b0, 32'h10,       1'b0, "sll");
    apply(OP_SRA,   32'd4,        32'h80000000, 1'b0, 32'hF8000000, 1'b0, "sra");
    apply(OP_SRL,   32'd4,        32'h80000000, 1'b0, 32'h08000000, 1'b0, "srl");
    apply(OP_SLL,   32'h24,       32'd3,        1'b0, 32'h30,       1'b0, "sll_upper_a_ignored");
    apply(OP_SRL,   32'd0,        32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, "srl_by_zero");
    apply(OP_SRA,   32'd0,        32'h80000001, 1'b0, 32'h80000001, 1'b0, "sra_by_zero");
    apply(OP_LUI,   32'd0,        32'h00001234, 1'b0, 32'h12340000, 1'b0, "lui");
    apply(OP_PASS,  32'hCAFEBABE, 32'h1,        1'b0, 32'hCAFEBABE, 1'b0, "pass");

    apply(OP_MULT,  32'hFFFFFFFE, 32'd3,        1'b0, 32'h0,        1'b0, "mult_result0");
    apply(OP_MFHI,  32'd0,        32'd0,        1'b0, 32'hFFFFFFFF, 1'b0, "mult_hi");
    apply(OP_MFLO,  32'd0,        32'd0,        1'b0, 32'hFFFFFFFA, 1'b0, "mult_lo");
    apply(OP_MULTU, 32'hFFFFFFFF, 32'd2,        1'b0, 32'h0,        1'b0, "multu_result0");
    apply(OP_MFHI,  32'd0,        32'd0,        1'b0, 32'h1,        1'b0, "multu_hi");
    apply(OP_MFLO,  32'd0,        32'd0,        1'b0, 32'hFFFFFFFE, 1'b0, "multu_lo");
    apply(OP_DIV,   32'hFFFFFFF9, 32'd2,        1'b0, 32'h0,        1'b0, "div_result0");
    apply(OP_MFLO,  32'd0,        32'd0,        1'b0, 32'hFFFFFFFD, 1'b0, "div_lo");
    apply(OP_MFHI,  32'd0,        32'd0,        1'b0, 32'hFFFFFFFF, 1'b0, "div_hi");
    apply(OP_DIVU,  32'd5,        32'd0,        1'b0, 32'h0,        1'b0, "divu_zero_result0");
    apply(OP_MFLO,  32'd0,        32'd0,        1'b0, 32'hFFFFFFFD, 1'b0, "divu_zero_lo_kept");
    apply(OP_MFHI,  32'd0,        32'd0,        1'b0, 32'hFFFFFFFF, 1'b0, "divu_zero_hi_kept");
    apply(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, "div_ovf_result0");
    apply(OP_MFLO,  32'd0,        32'd0,        1'b0, 32'h80000000, 1'b0, "div_ovf_lo");
    apply(OP_MFHI,  32'd0,        32'd0,        1'b0, 32'h0,        1'b0, "div_ovf_hi");
    apply(OP_DIVU,  32'd7,        32'd2,        1'b0, 32'h0,        1'b0, "divu_result0");
    apply(OP_MFLO,  32'd0,        32'd0,        1'b0, 32'd3,        1'b0, "divu_lo");
    apply(OP_MFHI,  32'd0,        32'd0,        1'b0, 32'd1,        1'b0, "divu_hi");
    apply(OP_DIV,   32'd7,        32'hFFFFFFFE, 1'b0, 32'h0,        1'b0, "div_neg_b");
    apply(OP_MFLO,  32'd0,        32'd0,        1'b0, 32'hFFFFFFFD, 1'b0, "div_neg_b_lo");
    apply(OP_MFHI,  32'd0,        32'd0,        1'b0, 32'd1,        1'b0, "div_neg_b_hi");
    apply(OP_MTHI,  32'hA5,       32'd0,        1'b0, 32'h0,        1'b0, "mthi_result0");
    apply(OP_MFHI,  32'd0,        32'd0,        1'b0, 32'hA5,       1'b0, "mthi_hi");
    apply(OP_MTLO,  32'h5A,       32'd0,        1'b0, 32'h0,        1'b0, "mtlo_result0");
    apply(OP_MFLO,  32'd0,        32'd0,        1'b0, 32'h5A,       1'b0, "mtlo_lo");

    apply(OP_BEQ,   32'd5,        32'd5,        1'b0, 32'h0,        1'b1, "beq_eq");
    apply(OP_BEQ,   32'd5,        32'd6,        1'b0, 32'h0,        1'b0, "beq_ne");
    apply(OP_BNE,   32'd3,        32'd3,        1'b0, 32'h0,        1'b0, "bne_eq");
    apply(OP_BNE,   32'd3,        32'd4,        1'b0, 32'h0,        1'b1, "bne_ne");
    apply(OP_BGEZ,  32'd0,        32'hFFFFFFFF, 1'b0, 32'h0,        1'b1, "bgez_zero");
    apply(OP_BGEZ,  32'hFFFFFFFF, 32'd0,        1'b0, 32'h0,        1'b0, "bgez_neg");
    apply(OP_BGTZ,  32'd0,        32'd5,        1'b0, 32'h0,        1'b0, "bgtz_zero");
    apply(OP_BGTZ,  32'd1,        32'd0,        1'b0, 32'h0,        1'b1, "bgtz_pos");
    apply(OP_BLEZ,  32'd0,        32'd0,        1'b0, 32'h0,        1'b1, "blez_zero");
    apply(OP_BLEZ,  32'd1,        32'd0,        1'b0, 32'h0,        1'b0, "blez_pos");
    apply(OP_BLTZ,  32'h80000000, 32'd0,        1'b0, 32'h0,        1'b1, "bltz_min");
    apply(OP_BLTZ,  32'd0,        32'd0,        1'b0, 32'h0,        1'b0, "bltz_zero");
    apply(OP_ADD,   32'd5,        32'd5,        1'b0, 32'd10,       1'b0, "add_branch0");

    apply(5'd31,    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, "undef31");
    apply(5'd26,    32'h12345678, 32'h9,        1'b0, 32'h0,        1'b0, "undef26");
    apply(OP_MFHI,  32'd0,        32'd0,        1'b0, 32'hA5,       1'b0, "undef_hi_kept");
    apply(OP_MFLO,  32'd0,        32'd0,        1'b0, 32'h5A,       1'b0, "undef_lo_kept");

    apply(OP_MULT,  32'd7,        32'd7,        1'b1, 32'h0,        1'b0, "mult_under_reset");
    apply(OP_MFHI,  32'd0,        32'd0,        1'b0, 32'h0,        1'b0, "rst_wins_hi");
    apply(OP_MFLO,  32'd0,        32'd0,        1'b0, 32'h0,        1'b0, "rst_wins_lo");
    apply(OP_MULT,  32'd7,        32'd7,        1'b0, 32'h0,        1'b0, "mult_7x7");
    apply(OP_MFLO,  32'd0,        32'd0,        1'b0, 32'd49,       1'b0, "mult_7x7_lo");
    apply(OP_MFHI,  32'd0,        32'd0,        1'b0, 32'd0,        1'b0, "mult_7x7_hi");

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d responses still pending, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
